lsu_mem_port: RTL and testbench

- Load/store unit: the initiator side of the byte-enabled data-memory port.
- Accepts one load/store request at a time from the pipeline and validates it (funct3, alignment, range).
- Drives the memory address, byte-write-enable and write-data lanes, then captures and sign/zero-extends read data.
- Returns a single registered response with an error code; sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_load_extend.sv | 22 ++
 rtl/lsu_mem_port.sv | 156 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, error codes.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_FAULT    = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } lsu_err_e;

   // Access size in bytes from funct3[1:0].
   function automatic logic [2:0] size_bytes(logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of right-aligned load data according to funct3.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = 32'b0;
      case (funct3)
         F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
         F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
         F3_W:    ext = raw;
         F3_BU:   ext = {24'b0, raw[7:0]};
         F3_HU:   ext = {16'b0, raw[15:0]};
         default: ext = 32'b0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a byte-enabled data-memory port; one operation in flight,
// validated on acceptance and answered with a single registered response.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [2:0]               req_funct3,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [31:0]              resp_rdata,
   output logic [1:0]               resp_err,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [3:0]               mem_byte_write_enable,
   output logic [31:0]              mem_write_data,
   input  logic [31:0]              mem_read_data
);

   localparam logic [32:0] ADDR_LIMIT = (33'd1 << ADDRESS_WIDTH) - 33'd1;

   lsu_state_e               state_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [2:0]               funct3_q;
   logic                     write_q;
   lsu_err_e                 err_q;
   logic [3:0]               be_q;
   logic [31:0]              wdata_q;
   logic [31:0]              rdata_q;
   lsu_err_e                 resp_err_q;
   logic                     req_ready_q;
   logic                     resp_valid_q;

   logic        legal;
   logic        misalign;
   logic        fault;
   logic [32:0] last_byte;
   lsu_err_e    req_err;
   logic [3:0]  req_be;
   logic [31:0] req_lanes;
   logic [31:0] load_ext;

   always_comb begin
      legal = 1'b0;
      case (req_funct3)
         F3_B, F3_H, F3_W: legal = 1'b1;
         F3_BU, F3_HU:     legal = !req_write;
         default:          legal = 1'b0;
      endcase
   end

   assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

   // 33-bit sum so an access wrapping past 2**32 still counts as out of range.
   assign last_byte = {1'b0, req_addr} + {30'b0, size_bytes(req_funct3[1:0])} - 33'd1;
   assign fault     = last_byte > ADDR_LIMIT;

   always_comb begin
      if (!legal)        req_err = ERR_ILLEGAL;
      else if (misalign) req_err = ERR_MISALIGN;
      else if (fault)    req_err = ERR_FAULT;
      else               req_err = ERR_NONE;
   end

   always_comb begin
      req_be    = 4'b0000;
      req_lanes = 32'b0;
      case (req_funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001;
            req_lanes = {24'b0, req_wdata[7:0]};
         end
         2'b01: begin
            req_be    = 4'b0011;
            req_lanes = {16'b0, req_wdata[15:0]};
         end
         default: begin
            req_be    = 4'b1111;
            req_lanes = req_wdata;
         end
      endcase
   end

   lsu_load_extend u_load_extend (
      .funct3 (funct3_q),
      .raw    (mem_read_data),
      .ext    (load_ext)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         funct3_q     <= 3'b0;
         write_q      <= 1'b0;
         err_q        <= ERR_NONE;
         be_q         <= 4'b0;
         wdata_q      <= 32'b0;
         rdata_q      <= 32'b0;
         resp_err_q   <= ERR_NONE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q      <= req_addr[ADDRESS_WIDTH-1:0];
                  funct3_q    <= req_funct3;
                  write_q     <= req_write;
                  err_q       <= req_err;
                  // Lanes are prepared now so the write is presented for the whole ACCESS cycle.
                  if (req_write && (req_err == ERR_NONE)) begin
                     be_q    <= req_be;
                     wdata_q <= req_lanes;
                  end
                  req_ready_q <= 1'b0;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               be_q         <= 4'b0;
               wdata_q      <= 32'b0;
               rdata_q      <= (!write_q && (err_q == ERR_NONE)) ? load_ext : 32'b0;
               resp_err_q   <= err_q;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready             = req_ready_q;
   assign resp_valid            = resp_valid_q;
   assign resp_rdata            = rdata_q;
   assign resp_err              = resp_err_q;
   assign mem_addr              = addr_q;
   assign mem_write_data        = wdata_q;
   // A cycle with reset asserted must never commit a write.
   assign mem_byte_write_enable = be_q & {4{rst_n}};

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: byte-array memory, reference model, directed + random ops.
module tb_lsu_mem_port;

   localparam int AW    = 8;
   localparam int MEMSZ = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_rdata;
   logic [1:0]    resp_err;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_byte_write_enable;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDRESS_WIDTH(AW)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_write             (req_write),
      .req_funct3            (req_funct3),
      .req_addr              (req_addr),
      .req_wdata             (req_wdata),
      .resp_valid            (resp_valid),
      .resp_ready            (resp_ready),
      .resp_rdata            (resp_rdata),
      .resp_err              (resp_err),
      .mem_addr              (mem_addr),
      .mem_byte_write_enable (mem_byte_write_enable),
      .mem_write_data        (mem_write_data),
      .mem_read_data         (mem_read_data)
   );

   typedef struct {
      logic [1:0]  err;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      logic [7:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   resp_t      rq[$];
   wr_t        wq[$];
   logic [7:0] mem[MEMSZ];
   logic [7:0] ref_mem[MEMSZ];
   int         tests = 0;
   int         fails = 0;

   function automatic logic [7:0] init_byte(int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   assign mem_read_data = {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                           mem[mem_addr + 8'd1], mem[mem_addr]};

   // Memory: initial image, then byte writes on the enables seen at each edge.
   initial begin
      for (int i = 0; i < MEMSZ; i++) mem[i] = init_byte(i);
      forever begin
         @(posedge clk);
         for (int i = 0; i < 4; i++)
            if (mem_byte_write_enable[i])
               mem[mem_addr + 8'(i)] <= mem_write_data[8*i +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected writes and responses whenever the DUT presents them.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_byte_write_enable != 4'b0) begin
            if (wq.size() == 0) begin
               check("unexpected write be", {28'b0, mem_byte_write_enable}, 32'h0);
            end else begin
               wr_t w;
               w = wq.pop_front();
               check("write addr", {24'b0, mem_addr}, {24'b0, w.addr});
               check("write be", {28'b0, mem_byte_write_enable}, {28'b0, w.be});
               check("write data", mem_write_data, w.data);
            end
         end
         if (resp_valid && resp_ready) begin
            if (rq.size() == 0) begin
               check("unexpected response", 32'h1, 32'h0);
            end else begin
               resp_t r;
               r = rq.pop_front();
               check("resp err", {30'b0, resp_err}, {30'b0, r.err});
               check("resp rdata", resp_rdata, r.rdata);
            end
         end
      end
   end

   function automatic logic [1:0] model_err(bit wr, logic [2:0] f3, logic [31:0] a);
      int sz;
      if (wr ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
         return 2'b11;
      sz = 1 << f3[1:0];
      if ((a % sz) != 0) return 2'b01;
      if (longint'(a) + longint'(sz) > longint'(MEMSZ)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_ready"}, {31'b0, req_ready}, 32'h1);
      check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'h0);
      check({tag, " resp_rdata"}, resp_rdata, 32'h0);
      check({tag, " resp_err"}, {30'b0, resp_err}, 32'h0);
      check({tag, " mem_addr"}, {24'b0, mem_addr}, 32'h0);
      check({tag, " mem_wdata"}, mem_write_data, 32'h0);
      check({tag, " mem_be"}, {28'b0, mem_byte_write_enable}, 32'h0);
   endtask

   // Issue one op (called at posedge+1 with the unit idle). abort=1 asserts reset in ACCESS.
   task automatic run_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold, input bit abort);
      logic [1:0]  e;
      logic [31:0] exp_rd;
      int          sz;
      resp_t       r;
      wr_t         w;
      e      = model_err(wr, f3, a);
      sz     = 1 << f3[1:0];
      exp_rd = 32'h0;
      if (e == 2'b00 && !wr) begin
         for (int i = 0; i < sz; i++) exp_rd |= 32'(ref_mem[a + 32'(i)]) << (8 * i);
         if (f3 == 3'd0 && exp_rd[7])  exp_rd |= 32'hFFFF_FF00;
         if (f3 == 3'd1 && exp_rd[15]) exp_rd |= 32'hFFFF_0000;
      end
      check("req_ready before issue", {31'b0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = $urandom;
      if (abort) begin
         rst_n = 1'b0;
         @(posedge clk); #1;
         check_reset_outputs("mid-op reset");
         rst_n = 1'b1;
         @(posedge clk); #1;
         check("no resp after abort", {31'b0, resp_valid}, 32'h0);
         return;
      end
      if (e == 2'b00 && wr) begin
         w.addr = a[7:0];
         w.be   = 4'((1 << sz) - 1);
         w.data = 32'h0;
         for (int i = 0; i < sz; i++) begin
            w.data[8*i +: 8] = wd[8*i +: 8];
            ref_mem[a + 32'(i)] = wd[8*i +: 8];
         end
         wq.push_back(w);
      end
      r.err   = e;
      r.rdata = exp_rd;
      rq.push_back(r);
      check("resp_valid at N+1", {31'b0, resp_valid}, 32'h0);
      check("req_ready at N+1", {31'b0, req_ready}, 32'h0);
      @(posedge clk); #1;
      check("resp_valid at N+2", {31'b0, resp_valid}, 32'h1);
      for (int k = 0; k < hold; k++) begin
         check("hold resp_valid", {31'b0, resp_valid}, 32'h1);
         check("hold resp_rdata", resp_rdata, exp_rd);
         check("hold resp_err", {30'b0, resp_err}, {30'b0, e});
         check("hold req_ready", {31'b0, req_ready}, 32'h0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("resp_valid after consume", {31'b0, resp_valid}, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  f3;
      int          sel;
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_byte(i);
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
      run_op(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 1, 1'b0);
      run_op(1'b0, 3'b001, 32'h22, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b101, 32'h22, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b100, 32'h24, 32'h0, 0, 1'b0);
      run_op(1'b1, 3'b000, 32'h05, 32'h0000_0080, 0, 1'b0);
      run_op(1'b0, 3'b000, 32'h05, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b100, 32'h05, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'h04, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'h13, 32'h0, 0, 1'b0);
      run_op(1'b1, 3'b001, 32'h21, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(1'b0, 3'b011, 32'h20, 32'h0, 0, 1'b0);
      run_op(1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'hFC, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
      run_op(1'b1, 3'b001, 32'hFF, 32'h5555_5555, 0, 1'b0);
      run_op(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h5555_5555, 0, 1'b0);
      run_op(1'b0, 3'b000, 32'hFF, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'h30, 32'h0, 5, 1'b0);
      run_op(1'b1, 3'b010, 32'h20, 32'hAAAA_AAAA, 0, 1'b1);
      run_op(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0);

      for (int n = 0; n < 200; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6)       a = 32'($urandom_range(0, 255));
         else if (sel < 8)  a = 32'($urandom_range(240, 255));
         else if (sel == 8) a = 32'h100 + 32'($urandom_range(0, 7));
         else               a = $urandom;
         f3 = 3'($urandom_range(0, 7));
         run_op(1'($urandom_range(0, 1)), f3, a, $urandom, int'($urandom_range(0, 2)), 1'b0);
      end

      repeat (2) @(posedge clk);
      #1;
      check("responses outstanding", 32'(rq.size()), 32'h0);
      check("writes outstanding", 32'(wq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
